// File: rtl/rx_baud_gen.sv
// rx_baud_gen: hunts the RX start edge and emits 11 mid-bit baud ticks per 8N1 frame
module rx_baud_gen #(
    parameter logic [15:0] DEFAULT_DIV = 16'd5208,
    parameter logic [15:0] MIN_DIV     = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        en,
    input  logic        db_wr,
    input  logic        db_sel,
    input  logic [7:0]  db_data,
    output logic        baud,
    output logic        busy,
    output logic [15:0] div_active
);
    typedef enum logic [1:0] {HUNT, RUN, FLUSH} state_t;
    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q, fall;
    logic [15:0] shadow_q, shadow_d, active_q, active_d, cnt_q, cnt_d;
    logic [3:0]  tick_q, tick_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            shadow_q  <= DEFAULT_DIV;
            active_q  <= DEFAULT_DIV;
            cnt_q     <= 16'd0;
            tick_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
        end
    end
    assign fall       = rx_prev_q & ~rx_s_q;
    assign busy       = state_q != HUNT;
    assign div_active = active_q;
    always_comb begin
        shadow_d = shadow_q;
        if (db_wr) shadow_d = db_sel ? {db_data, shadow_q[7:0]} : {shadow_q[15:8], db_data};
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        tick_d   = tick_q;
        baud     = 1'b0;
        unique case (state_q)
            HUNT: begin
                // shadow_d lets a write land in active on the very next cycle
                active_d = (shadow_d < MIN_DIV) ? MIN_DIV : shadow_d;
                if (en && fall) begin
                    cnt_d   = (active_q >> 1) - 16'd1;
                    tick_d  = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                else begin
                    baud    = 1'b1;
                    cnt_d   = active_q - 16'd1;
                    tick_d  = tick_q + 4'd1;
                    state_d = (tick_q == 4'd0 && rx_s_q) ? HUNT : (tick_q == 4'd9) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                baud    = 1'b1;
                state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
        if (!en) begin
            state_d = HUNT;
            baud    = 1'b0;
        end
    end
endmodule

// File: tb/tb_rx_baud_gen.sv
// tb_rx_baud_gen: table-driven frames plus hand-written corner sequences, tick scoreboard
module tb_rx_baud_gen;
    logic        clk = 0, rst = 1, RX = 1, en = 1, db_wr = 0, db_sel = 0;
    logic [7:0]  db_data = 0;
    logic        baud, busy;
    logic [15:0] div_active;
    int          cyc = 0, n_tests = 0, n_fail = 0, tick_cnt = 0, idle_at = -1;
    logic        arm = 0, r1 = 1, r2 = 1;

    typedef struct { int cyc; logic chk; logic rx; logic last; } tick_t;
    typedef struct { logic [7:0] lo; logic [7:0] hi; logic [7:0] data; logic [15:0] div; } vec_t;
    tick_t exp_q[$];
    vec_t  vt[6];

    rx_baud_gen dut (.clk(clk), .rst(rst), .RX(RX), .en(en), .db_wr(db_wr), .db_sel(db_sel),
                     .db_data(db_data), .baud(baud), .busy(busy), .div_active(div_active));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        r1  <= RX;
        r2  <= r1;
    end

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    // receiver-side view: r2 is RX as it looked two cycles ago, matching the synchroniser
    always @(negedge clk) if (arm) begin
        tick_t it;
        if (baud) begin
            tick_cnt++;
            if (exp_q.size() == 0) check("unexpected_tick", 1, 0);
            else begin
                it = exp_q.pop_front();
                check("tick_cycle", cyc, it.cyc);
                if (it.chk) check("tick_rx", r2, it.rx);
                check("busy_at_tick", busy, 1);
                if (it.last) idle_at = cyc + 1;
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            it = exp_q.pop_front();
            check("missed_tick", cyc, it.cyc);
        end
        if (cyc == idle_at) check("busy_after_flush", busy, 0);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic s, input logic [7:0] v);
        db_sel = s; db_data = v; db_wr = 1;
        idle(1);
        db_wr = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int d, input int n);
        logic [9:0] fb;
        int p, h;
        fb = {1'b1, b, 1'b0};
        p  = cyc;
        h  = d / 2;
        for (int k = 1; k <= 10; k++)
            if (k <= n) exp_q.push_back('{p + 2 + h + (k - 1) * d, 1'b1, fb[k - 1], 1'b0});
        if (n == 11) exp_q.push_back('{p + 3 + h + 9 * d, 1'b0, 1'b1, 1'b1});
        for (int k = 0; k < 10; k++) begin
            RX = fb[k];
            idle(d);
        end
    endtask

    initial begin
        int n0, p;
        vt[0] = '{8'h10, 8'h00, 8'h55, 16'd16};
        vt[1] = '{8'h10, 8'h00, 8'hA3, 16'd16};
        vt[2] = '{8'h20, 8'h00, 8'h0F, 16'd32};
        vt[3] = '{8'h05, 8'h00, 8'hC3, 16'd5};
        vt[4] = '{8'h03, 8'h00, 8'h96, 16'd3};
        vt[5] = '{8'h01, 8'h00, 8'h81, 16'd2};
        idle(2);
        rst = 0;
        check("reset_baud", baud, 0);
        check("reset_busy", busy, 0);
        check("reset_div", div_active, 5208);
        arm = 1;
        idle(1000);
        for (int i = 0; i < 6; i++) begin
            wr(0, vt[i].lo);
            wr(1, vt[i].hi);
            idle(4);
            check("vec_div_active", div_active, vt[i].div);
            send_frame(vt[i].data, int'(vt[i].div), 11);
            idle(2 * int'(vt[i].div) + 10);
            check("vec_busy_idle", busy, 0);
            check("vec_ticks_pending", exp_q.size(), 0);
        end
        // glitch: three low cycles then high
        wr(0, 8'h10);
        wr(1, 8'h00);
        idle(4);
        p = cyc;
        exp_q.push_back('{p + 10, 1'b1, 1'b1, 1'b0});
        RX = 0;
        idle(3);
        RX = 1;
        idle(30);
        check("glitch_busy", busy, 0);
        check("glitch_pending", exp_q.size(), 0);
        send_frame(8'hA3, 16, 11);
        idle(42);
        // back-to-back frames
        n0 = tick_cnt;
        send_frame(8'h00, 16, 11);
        send_frame(8'hFF, 16, 11);
        idle(42);
        check("b2b_ticks", tick_cnt - n0, 22);
        // divisor write during a frame
        fork
            send_frame(8'h5A, 16, 11);
            begin
                idle(58);
                wr(1, 8'h01);
                idle(10);
                check("midframe_div_held", div_active, 16);
            end
        join
        idle(20);
        check("midframe_div_applied", div_active, 16'h0110);
        // clamp to MIN_DIV, then drop enable mid-frame
        wr(0, 8'h00);
        wr(1, 8'h00);
        idle(3);
        check("clamp_div", div_active, 2);
        fork
            send_frame(8'h3C, 2, 5);
            begin
                idle(12);
                en = 0;
                idle(1);
                check("en_drop_busy", busy, 0);
                check("en_drop_baud", baud, 0);
            end
        join
        idle(10);
        en = 1;
        idle(5);
        send_frame(8'h3C, 2, 11);
        idle(20);
        check("final_pending", exp_q.size(), 0);
        check("final_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_baud_gen.md
Name: rx_baud_gen

Overview:
- Upstream baud-tick source for the UART receive controller. Drives that controller's `baud` input with single-cycle ticks centred in each bit of an incoming 8N1 frame.
- Hunts for the RX start edge, realigns its divider to it, emits exactly the 11 ticks the receiver consumes per frame, then returns to hunting.
- The divisor is bus-programmable via shadow registers and applied only between frames.

Parameters:
- DEFAULT_DIV, 16'd5208, clk cycles per bit after reset (50 MHz / 9600 baud).
- MIN_DIV, 16'd2, smallest divisor honoured; smaller programmed values act as MIN_DIV.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- RX  input  1  raw serial line, asynchronous to clk; idle high.
- en  input  1  block enable; low forces HUNT and suppresses ticks.
- db_wr  input  1  divisor write strobe, one cycle.
- db_sel  input  1  0 = write low byte, 1 = write high byte.
- db_data  input  8  divisor byte.
- baud  output  1  one-cycle tick to the receive controller.
- busy  output  1  high while a frame is being timed (RUN state).
- div_active  output  16  divisor currently in use (for debug and bench).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates occur on posedge clk. rst is sampled only at posedge clk.
- Reset values:
  - baud = 0, busy = 0, state = HUNT.
  - shadow and active divisor = DEFAULT_DIV.
  - 2-flop RX synchroniser = 1'b1.
  - tick count = 0, down-counter = 0.
- Synchroniser: rx_s = RX delayed 2 flops.
- Falling edge: rx_s_prev == 1 && rx_s == 0.
- Divisor registers:
  - db_wr writes db_data into the shadow byte selected by db_sel. Writes are accepted in any state.
  - In HUNT, every cycle: active <= max(shadow, MIN_DIV).
  - A write in cycle N reaches active at N+1 if the block is still in HUNT. Otherwise it waits for the next HUNT cycle.
  - Writes never alter the timing of a frame in progress.
- State HUNT:
  - baud = 0, busy = 0.
  - If en && falling edge in cycle E: cnt <= (active>>1) - 1, tick count <= 0, go RUN. The first tick is therefore in cycle E + (active>>1).
- State RUN (busy = 1):
  - Each cycle: if cnt != 0, decrement cnt.
  - Else assert baud this cycle, cnt <= active - 1, tick count += 1.
  - Ticks 1..10 are spaced active cycles apart: start bit, D0..D7, stop bit.
  - Tick 1 glitch check: if rx_s == 1 at tick 1, the start was a glitch. The tick is still issued, and the block returns to HUNT next cycle. The receiver ignores it because RX is high.
  - After tick 10: the FLUSH sub-state asserts baud for exactly one cycle in the next cycle (tick 11, the receiver's buffer-write tick), then goes to HUNT. This ensures the next frame's start edge is hunted while the line is still in the stop bit.
- en deassert: in any state, next cycle is HUNT, baud = 0, busy = 0, and any partial frame is abandoned. While en is low, no edge is detected.
- Reset mid-frame: identical to power-up reset values on the next edge; no trailing tick.
- Edge rules:
  - Edges are ignored while in RUN.
  - An edge arriving in the same cycle as the FLUSH→HUNT transition is not detected. The stop bit guarantees at least (active>>1) cycles of margin before the next real start edge.
- Arithmetic: cnt is 16 bits unsigned; tick count is 4 bits. With active = 2, the first tick is in cycle E+1 (cnt loaded 0) and the spacing is 2.
- baud is never high for two consecutive cycles, except at tick 10 followed by tick 11.

Test Plan:
- Reset check: assert rst for 2 cycles -> baud=0, busy=0, div_active=5208. With RX held high for 1000 cycles, no baud pulse occurs.
- Single frame: program div=16 (db_sel0=0x10, db_sel1=0x00), idle, send 0x55 with 16-cycle bits -> first tick 8 cycles after synchronised edge. Ticks 2..10 are spaced 16 apart, tick 11 is one cycle after tick 10, busy drops the cycle after tick 11. The receiver under test outputs 0x55 with RDA=1.
- Glitch rejection: div=16, RX low for 3 cycles then high -> exactly one tick, busy low afterwards, no receiver write. The next genuine frame 0xA3 is received correctly.
- Back-to-back frames: div=16, send 0x00 then 0xFF with no idle gap -> 22 ticks total, both bytes received in order.
- Mid-frame divisor write: div=16, start frame, write high byte 0x01 at tick 4 -> remaining ticks keep 16-cycle spacing. div_active becomes 0x0110 on the first HUNT cycle after tick 11.
- Clamp and enable: write div=0x0000 -> div_active=2 and ticks spaced 2 cycles apart. Drop en at tick 5 -> baud stays low, busy=0 next cycle. Re-raise en and send 0x3C at div=2 -> received correctly.
